// File: rtl/final_result_arbiter.sv
// Round-robin two-way arbiter feeding the IEEE final-result packing stage:
// grants one producer, latches its fields/flags, strobes the load and holds valid until acked.
module final_result_arbiter #(
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_i,
  input  logic          sign0_i,
  input  logic          sign1_i,
  input  logic [EW-1:0] exp0_i,
  input  logic [EW-1:0] exp1_i,
  input  logic [SW-1:0] sgf0_i,
  input  logic [SW-1:0] sgf1_i,
  input  logic [1:0]    ovf_i,
  input  logic [1:0]    udf_i,
  input  logic          ack_i,
  output logic [1:0]    gnt_o,
  output logic          sign_o,
  output logic [EW-1:0] exp_o,
  output logic [SW-1:0] sgf_o,
  output logic          sel_a_o,
  output logic          sel_b_o,
  output logic          load_o,
  output logic          valid_o,
  output logic          owner_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q;
  logic          last_q;
  logic [1:0]    gnt_q;
  logic          sign_q;
  logic [EW-1:0] exp_q;
  logic [SW-1:0] sgf_q;
  logic          sel_a_q;
  logic          sel_b_q;
  logic          owner_q;
  logic          winner_d;

  // On contention the requester not granted last wins; a lone request always wins.
  always_comb begin
    winner_d = 1'b0;
    if (req_i == 2'b11)
      winner_d = ~last_q;
    else if (req_i[1])
      winner_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sgf_q   <= '0;
      sel_a_q <= 1'b0;
      sel_b_q <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      gnt_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q <= LOAD;
            last_q  <= winner_d;
            owner_q <= winner_d;
            gnt_q   <= winner_d ? 2'b10 : 2'b01;
            sign_q  <= winner_d ? sign1_i : sign0_i;
            exp_q   <= winner_d ? exp1_i : exp0_i;
            sgf_q   <= winner_d ? sgf1_i : sgf0_i;
            // Overflow dominates underflow so the two forcing selects stay exclusive.
            sel_a_q <= ovf_i[winner_d];
            sel_b_q <= udf_i[winner_d] & ~ovf_i[winner_d];
          end
        end
        LOAD: state_q <= HOLD;
        HOLD: begin
          if (ack_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign sign_o  = sign_q;
  assign exp_o   = exp_q;
  assign sgf_o   = sgf_q;
  assign sel_a_o = sel_a_q;
  assign sel_b_o = sel_b_q;
  assign owner_o = owner_q;
  assign load_o  = (state_q == LOAD);
  assign valid_o = (state_q == HOLD);
  assign busy_o  = (state_q != IDLE);

endmodule

// File: doc/final_result_arbiter.md
# final_result_arbiter

Controller and two-way arbiter for the IEEE final-result packing stage, the last phase of the FPU pipeline, which holds a sign/exponent/significand mux, overflow/underflow forcing and a loadable result register. Two upstream producers (requester 0 and requester 1, e.g. the add/subtract path and the multiply path) share one packing stage. This block grants one producer at a time in round-robin order, latches its operand fields and exception flags, and drives the stage's field inputs, its `sel_a`/`sel_b` forcing selects and its load strobe. It then holds a result-valid indication until the consumer acknowledges.

## Interface
- `EW`, default 8: exponent width (11 for double precision).
- `SW`, default 23: significand width (52 for double precision).
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `req_i`, input, 2: per-requester request; a requester holds its bit high, with its fields stable, until it sees its `gnt_o` bit.
- `sign0_i` / `sign1_i`, input, 1: sign of the largest operand, per requester.
- `exp0_i` / `exp1_i`, input, EW: final exponent, per requester.
- `sgf0_i` / `sgf1_i`, input, SW: final significand, per requester.
- `ovf_i`, input, 2: overflow flag, one bit per requester.
- `udf_i`, input, 2: underflow flag, one bit per requester.
- `ack_i`, input, 1: consumer has taken the packed result.
- `gnt_o`, output, 2: one-cycle capture acknowledge to the granted requester.
- `sign_o`, output, 1: field driven to the packing stage.
- `exp_o`, output, EW: field driven to the packing stage.
- `sgf_o`, output, SW: field driven to the packing stage.
- `sel_a_o`, output, 1: overflow select to the packing stage.
- `sel_b_o`, output, 1: underflow select to the packing stage.
- `load_o`, output, 1: packing-stage register load strobe.
- `valid_o`, output, 1: packed result is valid in the packing register.
- `owner_o`, output, 1: index of the requester whose result is being packed or held.
- `busy_o`, output, 1: state is not IDLE.

## Operation
- FSM states are IDLE, LOAD and HOLD. Every output is registered, or is a pure decode of the state register.
- **IDLE:**
  - If any `req_i` bit is high, pick a winner.
  - If both bits are high, the winner is the requester that was not granted last; pointer `last` resets to 1, so requester 0 wins first.
  - On the clock edge, capture the winner's sign/exp/sgf and flags into the output registers, set `owner_o`, update `last`, pulse `gnt_o[winner]`, and go to LOAD.
  - If no `req_i` bit is high, stay in IDLE.
- **Flag decode at capture:**
  - ovf=1 gives `sel_a_o`=1, `sel_b_o`=0.
  - udf=1 with ovf=0 gives `sel_a_o`=0, `sel_b_o`=1.
  - Both flags set is treated as overflow, so `sel_a_o`/`sel_b_o` are never 1 at the same time.
  - Neither flag set gives 0/0.
- **LOAD:** `load_o`=1 for exactly this one cycle, with fields and selects stable. Go to HOLD unconditionally.
- **HOLD:** `valid_o`=1. Fields, selects and `owner_o` are frozen. If `ack_i`=1, go to IDLE; otherwise stay in HOLD.
- `req_i` activity outside IDLE is ignored. A request is never lost: it stays pending until it is granted.
- `ack_i` outside HOLD is ignored.
- `busy_o` = (state != IDLE).

## Timing
- **Reset values:**
  - state = IDLE, `last` = 1.
  - `gnt_o`, `sign_o`, `exp_o`, `sgf_o`, `sel_a_o`, `sel_b_o`, `load_o`, `valid_o`, `owner_o` and `busy_o` all 0.
- **Reset mid-operation:** asserting `rst` in LOAD or HOLD aborts to IDLE immediately (asynchronous). No `load_o` and no `valid_o` are issued afterwards for the aborted item.
- **Latency:**
  - Request sampled at edge E0.
  - `gnt_o` and `load_o` are high in cycle E0..E1.
  - The packing register captures at E1.
  - `valid_o` is high from E1.
- `ack_i` is accepted in the first HOLD cycle. The shortest turnaround is 3 cycles per result (IDLE, LOAD, HOLD).
- Back-to-back: after an ack, the next grant occurs at the next edge from IDLE when a request is pending.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0, 1, 0, 1, ...

## Test plan
- **Reset check:** reset, then release with no requests → all outputs 0 and `busy_o`=0 for 10 cycles.
- **Single request, normal result:** `req_i`=01, sign0=1, exp0=8'h85, sgf0=23'h123456, flags 0 → `gnt_o`=01 and `load_o`=1 in the same cycle with `sel_a_o`/`sel_b_o`=0/0; `valid_o`=1 next cycle; `ack_i` → IDLE.
- **Exception forcing:** requester 1 with ovf=1 → `sel_a_o`=1, `sel_b_o`=0. Requester 1 with udf=1 → 0/1. Requester 1 with both flags set → 1/0.
- **Contention:** `req_i`=11 held throughout, `ack_i` tied high → grants 0, 1, 0, 1 every 3 cycles; `owner_o` tracks the grant.
- **Consumer stall:** `ack_i` held low 5 cycles in HOLD while `req_i`=10 is pending → `valid_o` and fields stay frozen and `gnt_o` stays 0; when `ack_i` goes high, requester 1 is granted 1 cycle after returning to IDLE.
- **Mid-operation reset:** assert `rst` during LOAD → outputs 0 asynchronously; after release with `req_i`=11, requester 0 is granted first.
